// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide (shift-add / restoring divide)
// Revision    : 1.0
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int W     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int             c_cw   = $clog2(W);
  localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [TAG_W-1:0]  r_tag;
  logic              r_sa;
  logic              r_sb;
  logic [2*W-1:0]    r_acc;
  logic [W-1:0]      r_bmag;
  logic [c_cw-1:0]   r_cnt;

  logic              w_a_signed, w_b_signed, w_sa, w_sb;
  logic [W-1:0]      w_amag, w_bmag;
  logic              w_special;
  logic [W-1:0]      w_spec_res;
  logic [W:0]        w_mul_sum, w_div_diff;
  logic [2*W-1:0]    w_mul_next, w_div_next, w_prod;
  logic [W-1:0]      w_quo, w_rem, w_fix_res;

  assign in_ready = (r_state == IDLE) && rst_n;
  assign busy     = (r_state != IDLE);

  // MULHSU treats only a as signed; plain MUL's low half is sign-agnostic
  assign w_a_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign w_b_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
  assign w_sa       = w_a_signed & in_a[W-1];
  assign w_sb       = w_b_signed & in_b[W-1];
  assign w_amag     = w_sa ? -in_a : in_a;
  assign w_bmag     = w_sb ? -in_b : in_b;

  always_comb begin
    w_special  = 1'b0;
    w_spec_res = '0;
    if (in_op[2]) begin
      if (in_b == '0) begin
        w_special  = 1'b1;
        w_spec_res = in_op[1] ? in_a : '1;
      end else if (!in_op[0] && (in_a == {1'b1, {(W-1){1'b0}}}) && (&in_b)) begin
        w_special  = 1'b1;
        w_spec_res = in_op[1] ? '0 : in_a;
      end
    end
  end

  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_bmag} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};
  // Upper half after the left shift needs W+1 bits to compare against |b|
  assign w_div_diff = r_acc[2*W-1:W-1] - {1'b0, r_bmag};
  assign w_div_next = w_div_diff[W] ? {r_acc[2*W-2:0], 1'b0}
                                    : {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_sa ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'd0:                w_fix_res = w_prod[W-1:0];
      3'd1, 3'd2, 3'd3:    w_fix_res = w_prod[2*W-1:W];
      3'd4, 3'd5:          w_fix_res = w_quo;
      default:             w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_tag      <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_acc      <= '0;
      r_bmag     <= '0;
      r_cnt      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      r_state   <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_op   <= in_op;
            r_tag  <= in_tag;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_bmag <= w_bmag;
            r_acc  <= {{W{1'b0}}, w_amag};
            r_cnt  <= '0;
            if (w_special) begin
              out_result <= w_spec_res;
              out_tag    <= in_tag;
              out_valid  <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_state <= FIXUP;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end
        FIXUP: begin
          out_result <= w_fix_res;
          out_tag    <= r_tag;
          out_valid  <= 1'b1;
          r_state    <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_unit : vector table, random ops vs. arithmetic model, corner sequences
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W     = 32;
  localparam int TAG_W = 5;
  localparam int c_lat = W + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit #(.W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] qa, qb, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    qa = a;
    qb = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        q = qa / qb; return q;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        q = qa % qb; return q;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge right after the accept edge
  task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    #1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
  endtask

  // Edges counted after the accept edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input bit special);
    int lat;
    offer(op, a, b, tag);
    wait_valid(lat);
    check({name, "_result"}, out_result, exp);
    check({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
    check({name, "_latency"}, lat, special ? 32'd0 : c_lat);
    take();
  endtask

  initial begin
    vec_t tbl[12];
    int   lat;
    bit   seen;
    logic [2:0]  op;
    logic [31:0] a, b;

    tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{3'd2, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b0};
    tbl[3]  = '{3'd3, 32'hFFFFFFFF, 32'h2, 32'h00000001, 1'b0};
    tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 1'b0};
    tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{3'd5, 32'h7,        32'h2, 32'h3,        1'b0};
    tbl[7]  = '{3'd7, 32'h7,        32'h2, 32'h1,        1'b0};
    tbl[8]  = '{3'd5, 32'h5,        32'h0, 32'hFFFFFFFF, 1'b1};
    tbl[9]  = '{3'd6, 32'h5,        32'h0, 32'h5,        1'b1};
    tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_high", {31'd0, in_ready}, 32'd1);

    foreach (tbl[i])
      do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 3),
            tbl[i].exp, tbl[i].special);

    // Reset in the middle of a divide
    offer(3'd4, 32'd1000, 32'd7, 5'd17);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_result", out_result, 32'd0);
    check("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Backpressure with a second op offered while DONE
    offer(3'd0, 32'd3, 32'd5, 5'd9);
    wait_valid(lat);
    in_valid = 1'b1; in_op = 3'd3; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF; in_tag = 5'd4;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", out_result, 32'd15);
      check("bp_tag", {27'd0, out_tag}, 32'd9);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accept", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check("bp_second_latency", lat, c_lat);
    check("bp_second_result", out_result, model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF));
    check("bp_second_tag", {27'd0, out_tag}, 32'd4);
    take();

    // Flush in CALC with a competing offer
    offer(3'd5, 32'd100, 32'd7, 5'd3);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd3; in_tag = 5'd1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    check("flush_no_activity", {31'd0, seen}, 32'd0);
    do_op("post_flush", 3'd7, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0);

    // Randomized ops against the arithmetic model
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h80000000;
        default: ;
      endcase
      do_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, 5'($urandom_range(0, 31)),
            model(op, a, b), is_special(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and computes it in a multi-cycle shift-add / restoring-divide datapath. It returns the result with a pass-through tag so the pipeline can write it back to the right destination register. Width and tag width are parametrised; RISC-V divide-by-zero and overflow semantics are handled in a fast path.

## Interface

- W, 32, operand/result width (even, ≥ 8)
- TAG_W, 5, width of pass-through tag (destination register index)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; `(state==IDLE) && rst_n`
- in_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_a  in  W  rs1 operand
- in_b  in  W  rs2 operand
- in_tag  in  TAG_W  tag returned with result
- flush  in  1  abort any in-flight or completed-but-unread operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  W  result
- out_tag  out  TAG_W  tag captured at accept
- busy  out  1  state != IDLE

## Operation

- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE: on `in_valid && in_ready` (the accept edge), latch op, tag, operand magnitudes and sign flags, and clear counter.
  - MUL*: operands are signed or unsigned per op (MULHSU: a signed, b unsigned).
  - DIV/REM: signed; DIVU/REMU: unsigned.
  - Next state is CALC, or DONE directly for the special cases below.
- CALC: one radix-2 step per cycle over a 2W-bit accumulator.
  - Multiply: conditional add of |b|, then shift right.
  - Divide: restoring subtract, then shift left.
  - Counter runs 0..W-1; on count W-1 the next state is FIXUP.
- FIXUP: apply sign correction and select the result, register out_result and out_tag, then go to DONE.
  - MUL → low W bits of the product.
  - MULH/MULHSU/MULHU → high W bits.
  - Product negated if sign flags differ.
  - Quotient negated if sign(a) ≠ sign(b).
  - Remainder takes sign of a.
- DONE: out_valid=1 and out_result/out_tag held stable until `out_ready`, then IDLE. No new accept in DONE, even when out_ready is high.
- Special cases are decided in the accept cycle; the next state is DONE with the result already registered:
  - DIV/DIVU with b=0 → quotient all-ones.
  - REM/REMU with b=0 → a.
  - DIV with a = -2^(W-1) and b = -1 → -2^(W-1).
  - REM with a = -2^(W-1) and b = -1 → 0.
- flush: at the next edge state → IDLE and out_valid → 0, from any state.
  - flush has priority over accept: an accept in the flush cycle is dropped.
- Reset (rst_n low at an edge), including mid-operation:
  - state IDLE, counter 0, out_valid 0, out_result 0, out_tag 0, busy 0.
  - in_ready is 0 while rst_n is low.

## Timing

- Normal op accepted at edge 0:
  - CALC on edges 1..W.
  - FIXUP on edge W+1.
  - out_valid high after edge W+1.
  - Latency W+1 cycles (33 at W=32).
- Special-case op accepted at edge 0: out_valid high after edge 0 (1-cycle latency).
- Result handshake:
  - Completes on the edge where out_valid && out_ready.
  - in_ready rises after that edge, so back-to-back throughput is one op per W+3 cycles.
- out_valid never drops without a handshake, flush, or reset.
- Inputs are ignored outside the accept edge; operands may change freely during CALC.

## Test plan

- Reset: hold rst_n=0 for 2 cycles mid-CALC of a DIV → after the edge busy=0, out_valid=0, out_result=0; in_ready=1 once rst_n=1.
- MUL/MULH/MULHSU/MULHU with a=0xFFFFFFFF, b=0x00000002 →
  - MUL 0xFFFFFFFE.
  - MULH 0xFFFFFFFF.
  - MULHSU 0xFFFFFFFF.
  - MULHU 0x00000001.
  - Each with out_valid exactly 33 cycles after accept and tag echoed.
- DIV a=-7, b=2 → -3; REM → -1; DIVU a=7, b=2 → 3; REMU → 1.
- Special cases:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - Each with out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 → result and tag stable, in_ready=0, no second accept; release → handshake, then accept on the next cycle.
- Flush: flush at CALC cycle 5 while in_valid=1 → IDLE after the edge, no out_valid, offered op not accepted; the next op completes with the correct result.
